// File: rtl/usb_wire_symbol_packer.sv
// Packs 2-bit USB line symbols into byte-wide FIFO entries {data, nsym, last}
// and closes each packet with a "last" entry when the core stops driving.
module usb_wire_symbol_packer #(
  parameter int FIFO_DEPTH      = 64,
  parameter int FIFO_ADDR_WIDTH = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 sym_i,
  input  logic                       sym_tick_i,
  input  logic                       drive_i,
  input  logic                       rd_ready_i,
  output logic                       rd_valid_o,
  output logic [7:0]                 rd_data_o,
  output logic [2:0]                 rd_nsym_o,
  output logic                       rd_last_o,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_level_o,
  output logic                       ovf_o,
  output logic [7:0]                 drop_cnt_o,
  input  logic                       clr_ovf_i
);

  typedef logic [FIFO_ADDR_WIDTH-1:0] ptrT;
  typedef logic [FIFO_ADDR_WIDTH:0]   lvlT;

  logic [7:0]  shiftReg;
  logic [1:0]  symCnt;
  logic        driveD;
  logic [11:0] fifoMem [FIFO_DEPTH];
  ptrT         wrPtr, rdPtr, nextRdPtr;
  lvlT         level, nextLevel;
  logic [11:0] headEntry, nextHead, pushEntry;
  logic        headValid, ovfFlag;
  logic [7:0]  dropCnt, mergedData;
  logic        packetEnd, accept, pushValid, isFull, popNow, doPush, dropNow;

  // Packing decision: flush on drive fall, otherwise emit on the fourth symbol
  always_comb begin
    packetEnd  = !drive_i && driveD;
    accept     = sym_tick_i && drive_i;
    mergedData = shiftReg | ({6'b000000, sym_i} << {symCnt, 1'b0});
    pushValid  = 1'b0;
    pushEntry  = 12'h000;
    if (packetEnd) begin
      // shiftReg is already zero when no symbols are held, giving the marker entry
      pushValid = 1'b1;
      pushEntry = {shiftReg, 1'b0, symCnt, 1'b1};
    end else if (accept && (symCnt == 2'd3)) begin
      pushValid = 1'b1;
      pushEntry = {mergedData, 3'd4, 1'b0};
    end else begin
      pushValid = 1'b0;
      pushEntry = 12'h000;
    end
  end

  // FIFO control and next head-of-queue selection
  always_comb begin
    isFull    = (level == lvlT'(FIFO_DEPTH));
    popNow    = headValid && rd_ready_i;
    doPush    = pushValid && (!isFull || popNow);
    dropNow   = pushValid && isFull && !popNow;
    nextRdPtr = popNow ? (rdPtr + ptrT'(1)) : rdPtr;
    case ({doPush, popNow})
      2'b10:   nextLevel = level + lvlT'(1);
      2'b01:   nextLevel = level - lvlT'(1);
      default: nextLevel = level;
    endcase
    if (nextLevel == lvlT'(0)) begin
      nextHead = 12'h000;
    end else if (doPush && (wrPtr == nextRdPtr)) begin
      nextHead = pushEntry;
    end else begin
      nextHead = fifoMem[nextRdPtr];
    end
  end

  // Symbol shift register, symbol count and drive history
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shiftReg <= 8'h00;
      symCnt   <= 2'd0;
      driveD   <= 1'b0;
    end else begin
      driveD <= drive_i;
      if (packetEnd) begin
        shiftReg <= 8'h00;
        symCnt   <= 2'd0;
      end else if (accept) begin
        shiftReg <= (symCnt == 2'd3) ? 8'h00 : mergedData;
        symCnt   <= symCnt + 2'd1;
      end
    end
  end

  // Entry storage
  always_ff @(posedge clk_i) begin
    if (!rst_i && doPush) begin
      fifoMem[wrPtr] <= pushEntry;
    end
  end

  // Pointers, level, registered head and overflow bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr     <= ptrT'(0);
      rdPtr     <= ptrT'(0);
      level     <= lvlT'(0);
      headEntry <= 12'h000;
      headValid <= 1'b0;
      ovfFlag   <= 1'b0;
      dropCnt   <= 8'h00;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + ptrT'(1);
      end
      rdPtr     <= nextRdPtr;
      level     <= nextLevel;
      headEntry <= nextHead;
      headValid <= (nextLevel != lvlT'(0));
      if (clr_ovf_i) begin
        ovfFlag <= dropNow;
        dropCnt <= dropNow ? 8'h01 : 8'h00;
      end else if (dropNow) begin
        ovfFlag <= 1'b1;
        if (dropCnt != 8'hFF) begin
          dropCnt <= dropCnt + 8'h01;
        end
      end
    end
  end

  assign rd_valid_o   = headValid;
  assign rd_data_o    = headEntry[11:4];
  assign rd_nsym_o    = headEntry[3:1];
  assign rd_last_o    = headEntry[0];
  assign fifo_level_o = level;
  assign ovf_o        = ovfFlag;
  assign drop_cnt_o   = dropCnt;

endmodule

// File: tb/tb_usb_wire_symbol_packer.sv
// Randomized and directed bench for usb_wire_symbol_packer against a
// queue-based packet/FIFO reference model.
module tb_usb_wire_symbol_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sym = 2'd0;
  logic       tick = 1'b0, drive = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic       rdValid, rdLast, ovf;
  logic [7:0] rdData, dropCnt;
  logic [2:0] rdNsym;
  logic [6:0] level;

  always #5 clk = ~clk;

  usb_wire_symbol_packer dut (
    .clk_i(clk), .rst_i(rst), .sym_i(sym), .sym_tick_i(tick), .drive_i(drive),
    .rd_ready_i(rdy), .rd_valid_o(rdValid), .rd_data_o(rdData), .rd_nsym_o(rdNsym),
    .rd_last_o(rdLast), .fifo_level_o(level), .ovf_o(ovf), .drop_cnt_o(dropCnt),
    .clr_ovf_i(clr)
  );

  typedef struct { int data; int nsym; int last; } entryT;
  entryT q[$];
  int    symQ[$];
  bit    mDriveD = 1'b0;
  int    mOvf = 0, mDrop = 0;
  int    nVec = 0, nMis = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int packSyms();
    int v = 0;
    foreach (symQ[k]) v += symQ[k] * (4 ** k);
    return v;
  endfunction

  // Reference behaviour for one clock edge, using the inputs held across it
  task automatic modelEdge();
    entryT e;
    bit havePush = 1'b0, popNow, dropNow;
    if (!drive && mDriveD) begin
      e.data = packSyms(); e.nsym = symQ.size(); e.last = 1;
      symQ.delete(); havePush = 1'b1;
    end else if (tick && drive) begin
      symQ.push_back(int'(sym));
      if (symQ.size() == 4) begin
        e.data = packSyms(); e.nsym = 4; e.last = 0;
        symQ.delete(); havePush = 1'b1;
      end
    end
    mDriveD = drive;
    popNow  = (q.size() > 0) && rdy;
    dropNow = havePush && (q.size() == 64) && !popNow;
    if (popNow) void'(q.pop_front());
    if (havePush && !dropNow) q.push_back(e);
    if (clr) begin
      mOvf = dropNow ? 1 : 0; mDrop = dropNow ? 1 : 0;
    end else if (dropNow) begin
      mOvf = 1; if (mDrop < 255) mDrop++;
    end
  endtask

  task automatic checkOutputs();
    bit ne = q.size() > 0;
    checkVal("rd_valid", rdValid, ne);
    checkVal("rd_data", rdData, ne ? q[0].data : 0);
    checkVal("rd_nsym", rdNsym, ne ? q[0].nsym : 0);
    checkVal("rd_last", rdLast, ne ? q[0].last : 0);
    checkVal("fifo_level", level, q.size());
    checkVal("ovf", ovf, mOvf);
    checkVal("drop_cnt", dropCnt, mDrop);
  endtask

  task automatic step(input logic [1:0] s, input logic t, input logic d, input logic r, input logic c);
    sym = s; tick = t; drive = d; rdy = r; clr = c;
    @(posedge clk);
    modelEdge();
    #1 checkOutputs();
  endtask

  task automatic doReset();
    rst = 1'b1; sym = 2'd0; tick = 1'b0; drive = 1'b0; rdy = 1'b0; clr = 1'b0;
    @(posedge clk);
    q.delete(); symQ.delete(); mDriveD = 1'b0; mOvf = 0; mDrop = 0;
    #1 checkOutputs();
    rst = 1'b0;
  endtask

  // Symbol tick followed by an idle cycle, drive held high
  task automatic sendSym(input logic [1:0] s, input logic r);
    step(s, 1'b1, 1'b1, r, 1'b0);
    step(2'd0, 1'b0, 1'b1, r, 1'b0);
  endtask

  initial begin
    logic [1:0] p1 [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [1:0] p2 [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    logic dRand, rRand;

    doReset();
    checkVal("reset_valid", rdValid, 1'b0);

    // Eight symbols -> two full bytes plus a marker
    foreach (p1[i]) sendSym(p1[i], 1'b0);
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("t1_level", level, 7'd3);
    checkVal("t1_head0", rdData, 8'hE4);
    step(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("t1_head1", rdData, 8'h1B);
    step(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("t1_marker", {rdData, rdNsym, rdLast}, {8'h00, 3'd0, 1'b1});
    step(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Five symbols -> full byte plus one-symbol flush
    foreach (p2[i]) sendSym(p2[i], 1'b0);
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("t2_head0", {rdData, rdNsym, rdLast}, {8'h55, 3'd4, 1'b0});
    step(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("t2_flush", {rdData, rdNsym, rdLast}, {8'h02, 3'd1, 1'b1});
    step(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Ticks while not driving, and a tick on the falling edge of drive
    for (int i = 0; i < 4; i++) step(2'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    sendSym(2'd1, 1'b0);
    sendSym(2'd3, 1'b0);
    step(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("t3_level", level, 7'd1);
    checkVal("t3_flush", {rdData, rdNsym, rdLast}, {8'h0D, 3'd2, 1'b1});

    // Fill to full, overflow, then push with simultaneous pop
    doReset();
    for (int i = 0; i < 256 + 12; i++) step(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("t4_level", level, 7'd64);
    checkVal("t4_ovf", ovf, 1'b1);
    checkVal("t4_drops", dropCnt, 8'd3);
    for (int i = 0; i < 3; i++) step(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0, 1'b0);
    step(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b1, 1'b0);
    checkVal("t4_pushpop_level", level, 7'd64);
    checkVal("t4_pushpop_drops", dropCnt, 8'd3);
    for (int i = 0; i < 3; i++) step(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0, 1'b0);
    step(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0, 1'b1);
    checkVal("t4_clr_drop_ovf", ovf, 1'b1);
    checkVal("t4_clr_drop_cnt", dropCnt, 8'd1);
    step(2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkVal("t4_clr_cnt", dropCnt, 8'd0);
    for (int i = 0; i < 70; i++) step(2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkVal("t4_drained", level, 7'd0);

    // Reset mid-packet discards the partial byte
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) sendSym(2'd3, 1'b0);
    doReset();
    for (int i = 0; i < 4; i++) step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("t5_valid", rdValid, 1'b0);
    checkVal("t5_all", {rdData, rdNsym, rdLast, level}, 19'd0);

    // Stream of single-byte packets, draining every cycle
    for (int p = 0; p < 200; p++) begin
      for (int i = 0; i < 4; i++) step(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b1, 1'b0);
      step(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkVal("t6_no_ovf", ovf, 1'b0);
    checkVal("t6_no_drops", dropCnt, 8'd0);

    // Random traffic with varying consumer rate
    dRand = 1'b0;
    for (int blk = 0; blk < 8; blk++) begin
      int rdyPct = (blk % 2 == 0) ? 15 : 80;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 99) < 8) dRand = ~dRand;
        rRand = $urandom_range(0, 99) < rdyPct;
        step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), dRand, rRand,
             1'($urandom_range(0, 99) < 2));
      end
      if (blk == 4) begin
        doReset();
        dRand = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
